// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types for the PC redirect controller: state encoding and flush counter width.
// The state is derived from the pending flag and flush count so the encoding cannot drift from them.
package pc_redirect_ctrl_pkg;

    localparam int FLUSH_CNT_W = 3;

    typedef enum logic [1:0] {
        PCC_IDLE  = 2'd0,
        PCC_PEND  = 2'd1,
        PCC_FLUSH = 2'd2
    } pcc_state_e;

    // A parked redirect outranks an active flush.
    function automatic pcc_state_e pcc_state_of(input logic                   pend_vld,
                                                input logic [FLUSH_CNT_W-1:0] flush_cnt);
        if (pend_vld) begin
            return PCC_PEND;
        end
        if (flush_cnt != '0) begin
            return PCC_FLUSH;
        end
        return PCC_IDLE;
    endfunction

endpackage

// File: rtl/pc_redirect_ctrl.sv
// PC sequencing: merges stall requests, arbitrates trap vs. execute redirects,
// parks a redirect that arrives under hold, and flushes IF/ID after each issued redirect.
//
// state     | meaning
// PCC_IDLE  | nothing parked, no flush in progress; execute jumps accepted
// PCC_PEND  | a redirect is parked waiting for hold to drop
// PCC_FLUSH | flush in progress, nothing parked; execute jumps are squashed
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold_ex_i,
    input  logic              hold_bus_i,
    input  logic              ex_jmp_en_i,
    input  logic [ADDR_W-1:0] ex_jmp_addr_i,
    input  logic              trap_req_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    output logic              trap_ack_o,
    output logic              pc_hold_o,
    output logic              pc_jmp_en_o,
    output logic [ADDR_W-1:0] pc_jmp_addr_o,
    output logic              flush_o
);

    // The issue cycle itself is the first flush cycle, so the counter covers the remainder.
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    pcc_state_e               state_q;
    logic                     pend_is_trap_q, pend_is_trap_d;
    logic [ADDR_W-1:0]        pend_addr_q, pend_addr_d;
    logic [FLUSH_CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic                     pend_vld_d;

    logic                     hold;
    logic                     pend_vld;
    logic                     ex_ok;
    logic                     issue;
    logic                     ack;
    logic [ADDR_W-1:0]        issue_addr;
    logic [ADDR_W-1:0]        cand_addr;

    always_comb begin
        hold           = hold_ex_i | hold_bus_i;
        pend_vld       = (state_q == PCC_PEND);
        ex_ok          = ex_jmp_en_i && (state_q == PCC_IDLE);
        cand_addr      = trap_req_i ? trap_addr_i : ex_jmp_addr_i;
        pend_vld_d     = pend_vld;
        pend_is_trap_d = pend_is_trap_q;
        pend_addr_d    = pend_addr_q;
        flush_cnt_d    = flush_cnt_q;
        issue          = 1'b0;
        issue_addr     = '0;
        ack            = 1'b0;

        if (pend_vld) begin
            if (!hold) begin
                issue          = 1'b1;
                issue_addr     = pend_addr_q;
                pend_vld_d     = 1'b0;
                pend_is_trap_d = 1'b0;
                flush_cnt_d    = FLUSH_LOAD;
            end else if (trap_req_i && !pend_is_trap_q) begin
                // Trap displaces a parked jump; a second trap waits for the first to issue.
                pend_is_trap_d = 1'b1;
                pend_addr_d    = trap_addr_i;
                ack            = 1'b1;
            end
        end else if (trap_req_i || ex_ok) begin
            ack = trap_req_i;
            if (!hold) begin
                issue       = 1'b1;
                issue_addr  = cand_addr;
                flush_cnt_d = FLUSH_LOAD;
            end else begin
                pend_vld_d     = 1'b1;
                pend_is_trap_d = trap_req_i;
                pend_addr_d    = cand_addr;
            end
        end else if (!hold && (flush_cnt_q != '0)) begin
            flush_cnt_d = flush_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= PCC_IDLE;
            pend_is_trap_q <= 1'b0;
            pend_addr_q    <= '0;
            flush_cnt_q    <= '0;
        end else begin
            state_q        <= pcc_state_of(pend_vld_d, flush_cnt_d);
            pend_is_trap_q <= pend_is_trap_d;
            pend_addr_q    <= pend_addr_d;
            flush_cnt_q    <= flush_cnt_d;
        end
    end

    // Outputs are forced low while reset is asserted, including the combinational hold path.
    assign pc_hold_o     = hold & ~rst;
    assign pc_jmp_en_o   = issue & ~rst;
    assign pc_jmp_addr_o = rst ? '0 : issue_addr;
    assign trap_ack_o    = ack & ~rst;
    assign flush_o       = ((flush_cnt_q != '0) | issue) & ~rst;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl with a per-cycle reference model and literal spot checks.
module tb_pc_redirect_ctrl;

    localparam int ADDR_W       = 32;
    localparam int FLUSH_CYCLES = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              hold_ex_i = 1'b0;
    logic              hold_bus_i = 1'b0;
    logic              ex_jmp_en_i = 1'b0;
    logic [ADDR_W-1:0] ex_jmp_addr_i = '0;
    logic              trap_req_i = 1'b0;
    logic [ADDR_W-1:0] trap_addr_i = '0;
    logic              trap_ack_o;
    logic              pc_hold_o;
    logic              pc_jmp_en_o;
    logic [ADDR_W-1:0] pc_jmp_addr_o;
    logic              flush_o;

    int total = 0;
    int bad   = 0;

    pc_redirect_ctrl #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk           (clk),
        .rst           (rst),
        .hold_ex_i     (hold_ex_i),
        .hold_bus_i    (hold_bus_i),
        .ex_jmp_en_i   (ex_jmp_en_i),
        .ex_jmp_addr_i (ex_jmp_addr_i),
        .trap_req_i    (trap_req_i),
        .trap_addr_i   (trap_addr_i),
        .trap_ack_o    (trap_ack_o),
        .pc_hold_o     (pc_hold_o),
        .pc_jmp_en_o   (pc_jmp_en_o),
        .pc_jmp_addr_o (pc_jmp_addr_o),
        .flush_o       (flush_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: parked redirect plus "unheld flush cycles still owed".
    bit          m_pend = 1'b0;
    bit          m_ptrap = 1'b0;
    logic [31:0] m_paddr = '0;
    int          m_flush_left = 0;

    always @(negedge clk) begin
        bit          held, live_ex, e_issue, e_ack, e_flush;
        logic [31:0] e_addr;
        held    = hold_ex_i | hold_bus_i;
        e_issue = 1'b0;
        e_ack   = 1'b0;
        e_addr  = '0;
        e_flush = 1'b0;
        if (rst) begin
            held = 1'b0;
            m_pend = 1'b0;
            m_ptrap = 1'b0;
            m_paddr = '0;
            m_flush_left = 0;
        end else begin
            live_ex = ex_jmp_en_i && !m_pend && (m_flush_left == 0);
            if (m_pend) begin
                if (!held) begin
                    e_issue = 1'b1;
                    e_addr  = m_paddr;
                    m_pend  = 1'b0;
                    m_ptrap = 1'b0;
                end else if (trap_req_i && !m_ptrap) begin
                    m_paddr = trap_addr_i;
                    m_ptrap = 1'b1;
                    e_ack   = 1'b1;
                end
            end else if (trap_req_i || live_ex) begin
                e_ack = trap_req_i;
                if (!held) begin
                    e_issue = 1'b1;
                    e_addr  = trap_req_i ? trap_addr_i : ex_jmp_addr_i;
                end else begin
                    m_pend  = 1'b1;
                    m_ptrap = trap_req_i;
                    m_paddr = trap_req_i ? trap_addr_i : ex_jmp_addr_i;
                end
            end
            if (e_issue) m_flush_left = FLUSH_CYCLES;
            e_flush = (m_flush_left > 0);
            if (!held && m_flush_left > 0) m_flush_left--;
        end
        check("model_hold",    {31'd0, pc_hold_o},   {31'd0, held});
        check("model_jmp_en",  {31'd0, pc_jmp_en_o}, {31'd0, e_issue});
        check("model_jmp_addr", pc_jmp_addr_o,       e_addr);
        check("model_ack",     {31'd0, trap_ack_o},  {31'd0, e_ack});
        check("model_flush",   {31'd0, flush_o},     {31'd0, e_flush});
    end

    // Apply one cycle of inputs just after the rising edge; returns before the falling edge.
    task automatic step(input bit r, input bit hex, input bit hbus, input bit jen,
                        input logic [31:0] ja, input bit treq, input logic [31:0] ta);
        @(posedge clk);
        #1;
        rst           = r;
        hold_ex_i     = hex;
        hold_bus_i    = hbus;
        ex_jmp_en_i   = jen;
        ex_jmp_addr_i = ja;
        trap_req_i    = treq;
        trap_addr_i   = ta;
        #3;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic lit(input string name, input bit en, input logic [31:0] addr,
                       input bit ack, input bit fl);
        check({name, "_jmp_en"}, {31'd0, pc_jmp_en_o}, {31'd0, en});
        if (en) check({name, "_addr"}, pc_jmp_addr_o, addr);
        check({name, "_ack"},   {31'd0, trap_ack_o}, {31'd0, ack});
        check({name, "_flush"}, {31'd0, flush_o},    {31'd0, fl});
    endtask

    initial begin
        step(1, 1, 0, 1, 32'h55, 1, 32'h66);
        check("reset_hold", {31'd0, pc_hold_o}, 32'd0);
        lit("reset", 0, 0, 0, 0);
        step(1, 0, 0, 0, 32'h0, 0, 32'h0);
        idle();
        lit("post_reset", 0, 0, 0, 0);

        // 1: plain jump, two flush cycles
        step(0, 0, 0, 1, 32'h100, 0, 32'h0);  lit("t1_issue", 1, 32'h100, 0, 1);
        idle();                                lit("t1_fl2", 0, 0, 0, 1);
        idle();                                lit("t1_done", 0, 0, 0, 0);

        // 2: jump parked under bus hold, issued on release
        step(0, 0, 1, 1, 32'h200, 0, 32'h0);
        check("t2_hold", {31'd0, pc_hold_o}, 32'd1);
        lit("t2_h1", 0, 0, 0, 0);
        step(0, 0, 1, 1, 32'h200, 0, 32'h0);  lit("t2_h2", 0, 0, 0, 0);
        step(0, 0, 1, 1, 32'h200, 0, 32'h0);  lit("t2_h3", 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h200, 0, 32'h0);  lit("t2_issue", 1, 32'h200, 0, 1);
        idle(); idle();

        // 3: trap beats jump in the same cycle
        step(0, 0, 0, 1, 32'h300, 1, 32'h80); lit("t3_issue", 1, 32'h80, 1, 1);
        idle();                                lit("t3_after", 0, 0, 0, 1);
        idle();

        // 4: trap overwrites a parked jump, single issue on release
        step(0, 1, 0, 1, 32'h400, 0, 32'h0);  lit("t4_park", 0, 0, 0, 0);
        step(0, 1, 0, 1, 32'h400, 1, 32'h80); lit("t4_ack", 0, 0, 1, 0);
        step(0, 1, 0, 1, 32'h400, 0, 32'h0);  lit("t4_wait", 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h400, 0, 32'h0);  lit("t4_issue", 1, 32'h80, 0, 1);
        idle();                                lit("t4_single", 0, 0, 0, 1);
        idle();                                lit("t4_done", 0, 0, 0, 0);

        // 5: jumps squashed during flush; hold stretches the flush
        step(0, 0, 0, 1, 32'h600, 0, 32'h0);  lit("t5_issue", 1, 32'h600, 0, 1);
        step(0, 1, 0, 1, 32'h500, 0, 32'h0);  lit("t5_hold1", 0, 0, 0, 1);
        step(0, 1, 0, 0, 32'h0, 0, 32'h0);    lit("t5_hold2", 0, 0, 0, 1);
        idle();                                lit("t5_last", 0, 0, 0, 1);
        idle();                                lit("t5_done", 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h700, 0, 32'h0);  lit("t5b_issue", 1, 32'h700, 0, 1);
        step(0, 0, 0, 1, 32'h500, 0, 32'h0);  lit("t5b_squash", 0, 0, 0, 1);
        idle();                                lit("t5b_done", 0, 0, 0, 0);

        // trap during flush reloads the flush
        step(0, 0, 0, 1, 32'h800, 0, 32'h0);  lit("tr_issue", 1, 32'h800, 0, 1);
        step(0, 0, 0, 0, 32'h0, 1, 32'h90);   lit("tr_trap", 1, 32'h90, 1, 1);
        idle();                                lit("tr_fl2", 0, 0, 0, 1);
        idle();                                lit("tr_done", 0, 0, 0, 0);

        // second trap waits for the first parked trap to issue
        step(0, 0, 1, 0, 32'h0, 1, 32'hA0);   lit("tt_park", 0, 0, 1, 0);
        step(0, 0, 1, 0, 32'h0, 1, 32'hB0);   lit("tt_noack", 0, 0, 0, 0);
        step(0, 0, 0, 0, 32'h0, 1, 32'hB0);   lit("tt_first", 1, 32'hA0, 0, 1);
        step(0, 0, 0, 0, 32'h0, 1, 32'hB0);   lit("tt_second", 1, 32'hB0, 1, 1);
        idle(); idle();                        lit("tt_done", 0, 0, 0, 0);

        // 6: reset while a jump is parked
        step(0, 1, 0, 1, 32'hC00, 0, 32'h0);  lit("t6_park", 0, 0, 0, 0);
        step(1, 1, 0, 1, 32'hC00, 0, 32'h0);
        check("t6_rst_hold", {31'd0, pc_hold_o}, 32'd0);
        lit("t6_rst", 0, 0, 0, 0);
        idle();                                lit("t6_rel", 0, 0, 0, 0);
        idle();                                lit("t6_quiet", 0, 0, 0, 0);

        idle();
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
